// File: rtl/lzc_normalizer.sv
// Purpose: two-stage leading-zero counter and normaliser for FP mantissas.
//          Stage 1 registers the mantissa, exponent, zero count and zero flag.
//          Stage 2 registers the left-shifted mantissa and the adjusted exponent.
// Latency: 2 cycles from input transfer to out_valid. Throughput is 1 beat/clk.
// Backpressure: valid/ready elastic pipeline. A stalled stage holds all of its
//          registers. in_ready is low while rst is high.
// Ports:   clk, rst (sync, active-high); in_valid/in_ready/in_mant/in_exp;
//          out_valid/out_ready/out_mant/out_exp/out_lzc/out_zero/out_uflow.
// Option:  define LZC_EXP_CLAMP_EN to limit the shift to in_exp. The exponent
//          then never borrows, and the mantissa is left denormal on underflow.
module lzc_normalizer #(
    parameter  int WIDTH = 25,
    parameter  int EXPW  = 8,
    localparam int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXPW-1:0]  in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXPW-1:0]  out_exp,
    output logic [CNTW-1:0]  out_lzc,
    output logic             out_zero,
    output logic             out_uflow
);

    // The exponent and the count share a common width, with one extra bit so
    // that the top bit of the difference is the borrow.
    localparam int DW = ((EXPW > CNTW) ? EXPW : CNTW) + 1;

    // Stage 1 state
    logic             v1;
    logic [WIDTH-1:0] m1;
    logic [EXPW-1:0]  e1;
    logic [CNTW-1:0]  lzc1;
    logic             z1;

    // Stage 2 valid; the stage 2 data are the out_* registers themselves
    logic             v2;

    logic             ready1;
    logic             ready2;

    // Zeros above the highest set bit. An all-zero input reports 0.
    function automatic logic [CNTW-1:0] count_lz(input logic [WIDTH-1:0] m);
        logic [CNTW-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 1'b1;
                end
            end
        end
        if (!found) begin
            n = '0;
        end
        return n;
    endfunction

    assign ready2    = ~v2 | out_ready;
    assign ready1    = ~v1 | ready2;
    assign in_ready  = ~rst & ready1;
    assign out_valid = v2;

    // Stage 2 next-value logic
    logic [DW-1:0]    exp_ext;
    logic [DW-1:0]    lzc_ext;
    logic [DW-1:0]    shift_ext;
    logic [DW-1:0]    diff;
    logic [CNTW-1:0]  shift;
    logic [WIDTH-1:0] nxt_mant;
    logic [EXPW-1:0]  nxt_exp;
    logic             nxt_uflow;

    always_comb begin
        exp_ext = DW'(e1);
        lzc_ext = DW'(lzc1);
`ifdef LZC_EXP_CLAMP_EN
        // Never shift past the exponent. Any shortfall is reported as underflow.
        shift_ext = (lzc_ext > exp_ext) ? exp_ext : lzc_ext;
        nxt_uflow = (lzc_ext > exp_ext);
`else
        shift_ext = lzc_ext;
        nxt_uflow = 1'b0;
`endif
        shift    = shift_ext[CNTW-1:0];
        diff     = exp_ext - shift_ext;
        nxt_mant = m1 << shift;
        nxt_exp  = diff[EXPW-1:0];
`ifndef LZC_EXP_CLAMP_EN
        // A borrow out of the subtraction flushes the exponent to zero.
        if (diff[DW-1]) begin
            nxt_exp   = '0;
            nxt_uflow = 1'b1;
        end
`endif
        // A zero mantissa carries no exponent information.
        if (z1) begin
            nxt_exp   = '0;
            nxt_uflow = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            m1        <= '0;
            e1        <= '0;
            lzc1      <= '0;
            z1        <= 1'b0;
            v2        <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_lzc   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else begin
            if (ready1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    m1   <= in_mant;
                    e1   <= in_exp;
                    lzc1 <= count_lz(in_mant);
                    z1   <= ~|in_mant;
                end
            end
            if (ready2) begin
                v2 <= v1;
                if (v1) begin
                    out_mant  <= nxt_mant;
                    out_exp   <= nxt_exp;
                    out_lzc   <= shift;
                    out_zero  <= z1;
                    out_uflow <= nxt_uflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_lzc_normalizer.sv
module tb_lzc_normalizer;

    localparam int W = 25;
    localparam int E = 8;
    localparam int C = 5;

    typedef struct packed {
        logic [W-1:0] mant;
        logic [E-1:0] exp;
        logic [C-1:0] lzc;
        logic         zero;
        logic         uflow;
    } res_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_mant;
    logic [E-1:0] in_exp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_mant;
    logic [E-1:0] out_exp;
    logic [C-1:0] out_lzc;
    logic         out_zero;
    logic         out_uflow;

    int   tests = 0;
    int   fails = 0;
    res_t sb[$];
    bit   rand_rdy = 0;

    lzc_normalizer #(.WIDTH(W), .EXPW(E)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_lzc(out_lzc),
        .out_zero(out_zero), .out_uflow(out_uflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic res_t mk(logic [W-1:0] m, logic [E-1:0] e, logic [C-1:0] l,
                                logic z, logic u);
        res_t r;
        r.mant = m; r.exp = e; r.lzc = l; r.zero = z; r.uflow = u;
        return r;
    endfunction

    // Reference: position of the top set bit, then integer exponent arithmetic.
    function automatic res_t model(logic [W-1:0] m, logic [E-1:0] e);
        res_t r;
        int   top = -1;
        int   lz;
        int   sh;
        int   d;
        for (int i = 0; i < W; i++) if (m[i]) top = i;
        if (top < 0) return mk('0, '0, '0, 1'b1, 1'b0);
        lz = W - 1 - top;
        sh = lz;
`ifdef LZC_EXP_CLAMP_EN
        if (lz > int'(e)) sh = int'(e);
`endif
        d      = int'(e) - sh;
        r.mant = W'(m * (2 ** sh));
        r.lzc  = C'(sh);
        r.zero = 1'b0;
        if (d < 0) begin
            r.exp = '0; r.uflow = 1'b1;
        end else begin
            r.exp = E'(d); r.uflow = (lz > int'(e));
        end
        return r;
    endfunction

    function automatic res_t cur();
        return mk(out_mant, out_exp, out_lzc, out_zero, out_uflow);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the transfer edge.
    task automatic send(input logic [W-1:0] m, input logic [E-1:0] e, input res_t expv);
        int n    = 0;
        bit done = 0;
        in_valid = 1; in_mant = m; in_exp = e;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(expv);
                done = 1;
            end else if (++n > 200) begin
                tests++; fails++;
                $display("FAIL in_accept_timeout got=stalled expected=accepted");
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_latency();
        @(negedge clk);
        check("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer, checks holding.
    initial begin
        res_t prev;
        res_t got;
        res_t want;
        bit   stalled = 0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                got = cur();
                if (stalled) check("hold_stable", 64'(got), 64'(prev));
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat got=%0h expected=none", got);
                    end else begin
                        want = sb.pop_front();
                        check("out_beat", 64'(got), 64'(want));
                    end
                end
                stalled = !out_ready;
                prev    = got;
            end else begin
                stalled = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        res_t a;
        logic [W-1:0] m;
        logic [E-1:0] e;
        rst = 1; in_valid = 0; in_mant = '0; in_exp = '0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'(cur()), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed vectors with constant expectations
        out_ready = 1;
        send(25'h1000000, 8'd127, mk(25'h1000000, 8'd127, 5'd0, 1'b0, 1'b0));
        check_latency();
        send(25'h0000001, 8'd100, mk(25'h1000000, 8'd76, 5'd24, 1'b0, 1'b0));
        send(25'h0000000, 8'd55, mk(25'h0000000, 8'd0, 5'd0, 1'b1, 1'b0));
`ifdef LZC_EXP_CLAMP_EN
        send(25'h0000100, 8'd10, mk(25'h0040000, 8'd0, 5'd10, 1'b0, 1'b1));
`else
        send(25'h0000100, 8'd10, mk(25'h1000000, 8'd0, 5'd16, 1'b0, 1'b1));
`endif
        send(25'h0000001, 8'd24, mk(25'h1000000, 8'd0, 5'd24, 1'b0, 1'b0));
        send(25'h0012345, 8'd255, model(25'h0012345, 8'd255));
        drain();

        // Backpressure: A and B fill the pipe, C must stall
        out_ready = 0;
        a = model(25'h0003000, 8'd90);
        send(25'h0003000, 8'd90, a);
        send(25'h0400000, 8'd3, model(25'h0400000, 8'd3));
        in_valid = 1; in_mant = 25'h00000F0; in_exp = 8'd200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_mant_A", 64'(out_mant), 64'(a.mant));
            @(posedge clk); #1;
        end
        out_ready = 1;
        send(25'h00000F0, 8'd200, model(25'h00000F0, 8'd200));
        drain();

        // Reset with two beats in flight
        out_ready = 0;
        send(25'h0000ABC, 8'd40, model(25'h0000ABC, 8'd40));
        send(25'h1FFFFFF, 8'd1, model(25'h1FFFFFF, 8'd1));
        rst = 1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("after_rst_out_valid", 64'(out_valid), 64'd0);
        check("after_rst_outputs", 64'(cur()), 64'd0);
        out_ready = 1;
        @(posedge clk); #1;
        send(25'h0000040, 8'd30, model(25'h0000040, 8'd30));
        check_latency();
        repeat (5) @(posedge clk);
        #1;
        drain();

        // Randomised traffic with random backpressure
        rand_rdy = 1;
        for (int n = 0; n < 400; n++) begin
            m = W'($urandom);
            m = m >> $urandom_range(0, W);
            if ($urandom_range(0, 15) == 0) m = '0;
            e = ($urandom_range(0, 1) == 1) ? E'($urandom_range(0, 30)) : E'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(m, e, model(m, e));
        end
        rand_rdy  = 0;
        #0;
        out_ready = 1;
        drain();
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
